// File: rtl/pac_gfx_pkg.sv
// ---------------------------------------------------------------------------
// pac_gfx_pkg
//   Shared graphics constants and types for the maze frame buffer and the
//   sprite blitter.
//   Contents:
//     - frame-buffer / sprite geometry constants
//     - colour_idx_t  : 4-bit colour index
//     - blit_state_t  : blitter FSM states
//     - sprite_rom_addr() : ROM address from sprite number, row and column
// ---------------------------------------------------------------------------
package pac_gfx_pkg;

    localparam int SPR_W       = 16;    // sprite width, power of 2
    localparam int SPR_H       = 16;    // sprite height, power of 2
    localparam int FB_W        = 226;   // frame-buffer row pitch
    localparam int FB_H        = 248;   // frame-buffer height
    localparam int ADDR_W      = 20;    // frame-buffer and ROM address width
    localparam int COLOR_W     = 4;     // colour-index width
    localparam int TRANSPARENT = 0;     // colour index that is never written

    localparam int SPR_ID_W = 4;                 // sprite number width
    localparam int POS_W    = 8;                 // spr_x / spr_y width
    localparam int COL_W    = $clog2(SPR_W);     // column counter width
    localparam int ROW_W    = $clog2(SPR_H);     // row counter width
    localparam int DIM_W    = 9;                 // dx / dy width (pos + offset)
    localparam int MUL_W    = 18;                // dy*FB_W + dx working width

    typedef logic [COLOR_W-1:0] color_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } blit_state_t;

    // Sprites are stored back to back, SPR_W*SPR_H pixels each, row-major.
    // Because both dimensions are powers of two the address is a plain
    // concatenation of sprite number, row and column.
    function automatic logic [ADDR_W-1:0] sprite_rom_addr(
        input logic [SPR_ID_W-1:0] id,
        input logic [ROW_W-1:0]    row,
        input logic [COL_W-1:0]    col
    );
        return ADDR_W'({id, row, col});
    endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// ---------------------------------------------------------------------------
// sprite_blitter_if
//   Bundles the blitter's request handshake, sprite-ROM read port,
//   frame-buffer write port and VGA blanking input.
//   Modports:
//     master : the blitter (drives ROM address, FB write port, busy/done)
//     slave  : the surrounding system (drives request, ROM data, blanking)
// ---------------------------------------------------------------------------
interface sprite_blitter_if;
    import pac_gfx_pkg::*;

    // request handshake
    logic                start;
    logic [SPR_ID_W-1:0] spr_id;
    logic [POS_W-1:0]    spr_x;
    logic [POS_W-1:0]    spr_y;
    logic                busy;
    logic                done;

    // VGA blanking (0 = blanking, writes allowed)
    logic                vga_blank_n;

    // sprite ROM read port
    logic [ADDR_W-1:0]   rom_addr;
    color_idx_t          rom_data;

    // frame-buffer write port
    logic                fb_we;
    logic [ADDR_W-1:0]   fb_addr;
    color_idx_t          fb_data;

    modport master (
        input  start, spr_id, spr_x, spr_y, vga_blank_n, rom_data,
        output busy, done, rom_addr, fb_we, fb_addr, fb_data
    );

    modport slave (
        output start, spr_id, spr_x, spr_y, vga_blank_n, rom_data,
        input  busy, done, rom_addr, fb_we, fb_addr, fb_data
    );

endinterface

// File: rtl/blit_addr_gen.sv
// ---------------------------------------------------------------------------
// blit_addr_gen
//   Combinational destination-address generator for one sprite pixel.
//   Ports:
//     spr_x, spr_y : sprite top-left position in the frame buffer
//     row, col     : pixel position inside the sprite
//     fb_addr      : dy*FB_W + dx, truncated to ADDR_W
//     clip         : 1 when the pixel falls outside the frame buffer
// ---------------------------------------------------------------------------
module blit_addr_gen
    import pac_gfx_pkg::*;
(
    input  logic [POS_W-1:0]  spr_x,
    input  logic [POS_W-1:0]  spr_y,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              clip
);

    localparam logic [MUL_W-1:0] FB_W_VEC = MUL_W'(FB_W);

    logic [DIM_W-1:0] dx;
    logic [DIM_W-1:0] dy;
    logic [MUL_W-1:0] term [MUL_W];
    logic [MUL_W-1:0] row_base;
    logic [MUL_W-1:0] pix_addr;

    assign dx = DIM_W'(spr_x) + DIM_W'(col);
    assign dy = DIM_W'(spr_y) + DIM_W'(row);

    // dy*FB_W as a sum of shifted copies of dy, one per set bit of the
    // constant pitch; cleared bits contribute a constant zero.
    genvar gi;
    generate
        for (gi = 0; gi < MUL_W; gi++) begin : g_term
            if (FB_W_VEC[gi]) begin : g_on
                assign term[gi] = MUL_W'(dy) << gi;
            end else begin : g_off
                assign term[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        row_base = '0;
        for (int i = 0; i < MUL_W; i++) begin
            row_base = row_base + term[i];
        end
    end

    // Largest legal dy/dx is 270, giving 270*226 + 270 < 2^16.
    assign pix_addr = row_base + MUL_W'(dx);
    assign fb_addr  = ADDR_W'(pix_addr);
    assign clip     = (dx >= DIM_W'(FB_W)) || (dy >= DIM_W'(FB_H));

endmodule

// File: rtl/sprite_blitter.sv
// ---------------------------------------------------------------------------
// sprite_blitter
//   Copies one SPR_W x SPR_H sprite from a synchronous sprite ROM into the
//   colour-index frame buffer at (spr_x, spr_y). Transparent pixels are
//   skipped, off-buffer pixels are clipped, and visible pixels are written
//   only while the VGA output is blanked.
//   Ports:
//     Clk   : system clock
//     Reset : asynchronous, active-high reset
//     bus   : sprite_blitter_if.master (request, ROM read, FB write, blank)
//   Per pixel: READ presents the ROM address, WRITE sees the ROM data and
//   either writes, skips, or stalls until blanking.
// ---------------------------------------------------------------------------
module sprite_blitter
    import pac_gfx_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    sprite_blitter_if.master  bus
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPR_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SPR_H - 1);

    blit_state_t         state_reg,    state_next;
    logic [SPR_ID_W-1:0] spr_id_reg,   spr_id_next;
    logic [POS_W-1:0]    spr_x_reg,    spr_x_next;
    logic [POS_W-1:0]    spr_y_reg,    spr_y_next;
    logic [ROW_W-1:0]    row_reg,      row_next;
    logic [COL_W-1:0]    col_reg,      col_next;
    logic [ADDR_W-1:0]   rom_addr_reg, rom_addr_next;
    logic [ADDR_W-1:0]   fb_addr_reg,  fb_addr_next;
    logic                clip_reg,     clip_next;

    logic [ADDR_W-1:0]   fb_addr_calc;
    logic                clip_calc;
    logic                skip;
    logic                write_ok;
    logic                advance;
    logic                last_px;
    logic                fb_we;
    color_idx_t          fb_data;
    logic                done;

    blit_addr_gen u_addr_gen (
        .spr_x   (spr_x_reg),
        .spr_y   (spr_y_reg),
        .row     (row_reg),
        .col     (col_reg),
        .fb_addr (fb_addr_calc),
        .clip    (clip_calc)
    );

    // Pixels that would never be written must not wait for blanking.
    assign skip     = clip_reg || (bus.rom_data == color_idx_t'(TRANSPARENT));
    assign write_ok = !bus.vga_blank_n && !skip;
    assign advance  = skip || !bus.vga_blank_n;
    assign last_px  = (row_reg == ROW_MAX) && (col_reg == COL_MAX);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= IDLE;
            spr_id_reg   <= '0;
            spr_x_reg    <= '0;
            spr_y_reg    <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            rom_addr_reg <= '0;
            fb_addr_reg  <= '0;
            clip_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            spr_id_reg   <= spr_id_next;
            spr_x_reg    <= spr_x_next;
            spr_y_reg    <= spr_y_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            rom_addr_reg <= rom_addr_next;
            fb_addr_reg  <= fb_addr_next;
            clip_reg     <= clip_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        spr_id_next   = spr_id_reg;
        spr_x_next    = spr_x_reg;
        spr_y_next    = spr_y_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        rom_addr_next = rom_addr_reg;
        fb_addr_next  = fb_addr_reg;
        clip_next     = clip_reg;
        fb_we         = 1'b0;
        fb_data       = '0;
        done          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    spr_id_next   = bus.spr_id;
                    spr_x_next    = bus.spr_x;
                    spr_y_next    = bus.spr_y;
                    row_next      = '0;
                    col_next      = '0;
                    // Address is loaded on entry to READ so the ROM data
                    // arrives exactly in the following WRITE cycle.
                    rom_addr_next = sprite_rom_addr(bus.spr_id, '0, '0);
                    state_next    = READ;
                end
            end

            READ: begin
                // Capture the destination now so it is stable in WRITE.
                fb_addr_next = fb_addr_calc;
                clip_next    = clip_calc;
                state_next   = WRITE;
            end

            WRITE: begin
                fb_data = bus.rom_data;
                fb_we   = write_ok;
                if (advance) begin
                    col_next = col_reg + 1'b1;
                    if (col_reg == COL_MAX) begin
                        row_next = row_reg + 1'b1;
                    end
                    if (last_px) begin
                        state_next = DONE;
                    end else begin
                        rom_addr_next = sprite_rom_addr(spr_id_reg, row_next, col_next);
                        state_next    = READ;
                    end
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.rom_addr = rom_addr_reg;
    assign bus.fb_addr  = fb_addr_reg;
    assign bus.fb_we    = fb_we;
    assign bus.fb_data  = fb_data;
    assign bus.done     = done;
    assign bus.busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_sprite_blitter.sv
// ---------------------------------------------------------------------------
// tb_sprite_blitter
//   Directed bench for sprite_blitter: a synchronous sprite ROM model, a
//   write monitor on the frame-buffer port, and one linear sequence of
//   scenarios with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_sprite_blitter;
    import pac_gfx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int tests_run    = 0;
    int tests_failed = 0;

    sprite_blitter_if bus();

    sprite_blitter dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous sprite ROM: data one cycle after the address.
    logic [COLOR_W-1:0] rom_mem [0:4095];
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        bus.rom_data <= rom_mem[bus.rom_addr[11:0]];
    end

    // Frame-buffer write monitor, sampled on the falling edge.
    int          wr_count;
    int          first_we_cyc;
    int          done_cyc;
    int          done_count;
    int          bad_data;
    int          we_while_blank;
    logic [31:0] first_addr;
    logic [31:0] last_addr;
    logic [31:0] max_addr;
    logic [3:0]  exp_data;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.fb_we === 1'b1) begin
                if (wr_count == 0) begin
                    first_we_cyc = cyc;
                    first_addr   = 32'(bus.fb_addr);
                end
                last_addr = 32'(bus.fb_addr);
                if (32'(bus.fb_addr) > max_addr) max_addr = 32'(bus.fb_addr);
                if (bus.fb_data !== exp_data) bad_data++;
                if (bus.vga_blank_n !== 1'b0) we_while_blank++;
                wr_count++;
            end
            if (bus.done === 1'b1) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of cycle c (call from the driving phase).
    task automatic at_cycle(input int c);
        while (cyc < c) next_cycle();
        @(negedge clk);
    endtask

    task automatic clear_mon();
        wr_count       = 0;
        first_we_cyc   = -1;
        done_cyc       = -1;
        done_count     = 0;
        bad_data       = 0;
        we_while_blank = 0;
        first_addr     = '1;
        last_addr      = '1;
        max_addr       = '0;
    endtask

    task automatic start_blit(input int id, input int x, input int y, output int t);
        next_cycle();
        bus.spr_id = 4'(id);
        bus.spr_x  = 8'(x);
        bus.spr_y  = 8'(y);
        bus.start  = 1'b1;
        t = cyc;
        next_cycle();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int t);
        while (done_count == 0 && cyc < t + 1500) next_cycle();
    endtask

    task automatic fill_rom(input logic [3:0] v);
        for (int a = 0; a < 4096; a++) rom_mem[a] = v;
    endtask

    int t;
    logic [31:0] rom_a;
    logic [31:0] rom_b;

    initial begin
        bus.start       = 1'b0;
        bus.spr_id      = '0;
        bus.spr_x       = '0;
        bus.spr_y       = '0;
        bus.vga_blank_n = 1'b0;
        exp_data        = 4'h5;
        fill_rom(4'h5);
        clear_mon();

        // ---------------- reset state ----------------
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_busy",     32'(bus.busy),     0);
        chk("rst_done",     32'(bus.done),     0);
        chk("rst_fb_we",    32'(bus.fb_we),    0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        chk("rst_fb_addr",  32'(bus.fb_addr),  0);
        chk("rst_fb_data",  32'(bus.fb_data),  0);
        next_cycle();
        rst = 1'b0;
        repeat (2) next_cycle();
        $display("[TB] reset checked");

        // ---------------- 1: solid sprite ----------------
        clear_mon();
        exp_data = 4'h5;
        start_blit(2, 10, 20, t);
        at_cycle(t + 1);
        chk("s1_busy_t1",     32'(bus.busy),     1);
        chk("s1_rom_addr_t1", 32'(bus.rom_addr), 512);
        wait_done(t);
        at_cycle(t + 514);
        chk("s1_busy_t514",  32'(bus.busy), 0);
        chk("s1_writes",     32'(wr_count), 256);
        chk("s1_first_addr", first_addr, 4530);
        chk("s1_last_addr",  last_addr, 7935);
        chk("s1_first_we",   32'(first_we_cyc - t), 2);
        chk("s1_done_cyc",   32'(done_cyc - t), 513);
        chk("s1_bad_data",   32'(bad_data), 0);
        $display("[TB] s1 solid: writes=%0d first=%0d last=%0d done@+%0d", wr_count, first_addr, last_addr, done_cyc - t);

        // ---------------- 2: checkerboard ----------------
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                rom_mem[256 + r * 16 + c] = ((r + c) % 2 == 1) ? 4'h3 : 4'h0;
        next_cycle();
        clear_mon();
        exp_data = 4'h3;
        start_blit(1, 0, 0, t);
        wait_done(t);
        at_cycle(t + 514);
        chk("s2_writes",     32'(wr_count), 128);
        chk("s2_bad_data",   32'(bad_data), 0);
        chk("s2_first_addr", first_addr, 1);
        chk("s2_last_addr",  last_addr, 3404);
        chk("s2_done_cyc",   32'(done_cyc - t), 513);
        $display("[TB] s2 checker: writes=%0d first=%0d last=%0d done@+%0d", wr_count, first_addr, last_addr, done_cyc - t);

        // ---------------- 3: clipping at bottom-right ----------------
        next_cycle();
        clear_mon();
        exp_data = 4'h5;
        start_blit(2, 220, 240, t);
        wait_done(t);
        at_cycle(t + 514);
        chk("s3_writes",     32'(wr_count), 48);
        chk("s3_first_addr", first_addr, 54460);
        chk("s3_last_addr",  last_addr, 56047);
        chk("s3_max_in_fb",  32'(max_addr < 32'(FB_W * FB_H)), 1);
        chk("s3_done_cyc",   32'(done_cyc - t), 513);
        $display("[TB] s3 clip: writes=%0d first=%0d last=%0d done@+%0d", wr_count, first_addr, last_addr, done_cyc - t);

        // ---------------- 4: stall on active video ----------------
        next_cycle();
        clear_mon();
        start_blit(2, 10, 20, t);
        while (cyc < t + 5) next_cycle();
        bus.vga_blank_n = 1'b1;
        at_cycle(t + 6);
        rom_a = 32'(bus.rom_addr);
        at_cycle(t + 104);
        rom_b = 32'(bus.rom_addr);
        chk("s4_we_in_window", 32'(bus.fb_we), 0);
        while (cyc < t + 105) next_cycle();
        bus.vga_blank_n = 1'b0;
        wait_done(t);
        at_cycle(t + 613);
        chk("s4_rom_addr_a",  rom_a, 514);
        chk("s4_rom_addr_b",  rom_b, 514);
        chk("s4_we_blank",    32'(we_while_blank), 0);
        chk("s4_writes",      32'(wr_count), 256);
        chk("s4_done_cyc",    32'(done_cyc - t), 612);
        chk("s4_busy_after",  32'(bus.busy), 0);
        $display("[TB] s4 stall: writes=%0d done@+%0d rom_addr=%0d/%0d", wr_count, done_cyc - t, rom_a, rom_b);

        // ---------------- 5: start while busy ----------------
        next_cycle();
        clear_mon();
        start_blit(2, 10, 20, t);
        while (cyc < t + 50) next_cycle();
        bus.spr_x  = 8'd100;
        bus.spr_id = 4'd7;
        bus.start  = 1'b1;
        next_cycle();
        bus.start  = 1'b0;
        wait_done(t);
        at_cycle(t + 600);
        chk("s5_writes",     32'(wr_count), 256);
        chk("s5_first_addr", first_addr, 4530);
        chk("s5_last_addr",  last_addr, 7935);
        chk("s5_max_addr",   max_addr, 7935);
        chk("s5_done_count", 32'(done_count), 1);
        chk("s5_done_cyc",   32'(done_cyc - t), 513);
        chk("s5_idle",       32'(bus.busy), 0);
        $display("[TB] s5 ignore: writes=%0d dones=%0d max=%0d", wr_count, done_count, max_addr);

        // ---------------- 6: reset mid-blit ----------------
        next_cycle();
        clear_mon();
        start_blit(2, 10, 20, t);
        while (cyc < t + 200) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("s6_busy",     32'(bus.busy),     0);
        chk("s6_fb_we",    32'(bus.fb_we),    0);
        chk("s6_done",     32'(bus.done),     0);
        chk("s6_rom_addr", 32'(bus.rom_addr), 0);
        chk("s6_fb_addr",  32'(bus.fb_addr),  0);
        chk("s6_fb_data",  32'(bus.fb_data),  0);
        next_cycle();
        rst = 1'b0;
        clear_mon();
        repeat (5) next_cycle();
        @(negedge clk);
        chk("s6_no_writes_after", 32'(wr_count), 0);
        chk("s6_idle_after",      32'(bus.busy), 0);
        clear_mon();
        start_blit(2, 10, 20, t);
        wait_done(t);
        at_cycle(t + 514);
        chk("s6_writes",     32'(wr_count), 256);
        chk("s6_first_addr", first_addr, 4530);
        chk("s6_last_addr",  last_addr, 7935);
        chk("s6_done_cyc",   32'(done_cyc - t), 513);
        $display("[TB] s6 reset: writes=%0d first=%0d last=%0d done@+%0d", wr_count, first_addr, last_addr, done_cyc - t);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Write-side engine for the 4-bit colour-index maze frame buffer; the VGA/draw_control path reads that buffer to scan out.
- On a start pulse, copies one 16x16 sprite from a synchronous sprite ROM into the buffer at pixel (spr_x, spr_y).
- Colour-0 pixels are skipped; off-buffer pixels are clipped.
- Writes are issued only while the VGA output is blanked, so the scan-out reader never sees a half-drawn sprite.

Parameters:
- SPR_W, 16, sprite width in pixels (power of 2)
- SPR_H, 16, sprite height in pixels (power of 2)
- FB_W, 226, frame-buffer width in pixels (row pitch)
- FB_H, 248, frame-buffer height in pixels
- ADDR_W, 20, frame-buffer and ROM address width
- COLOR_W, 4, colour-index width
- TRANSPARENT, 0, colour index that is never written

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- spr_id  in  4  sprite number; ROM base = spr_id*SPR_W*SPR_H
- spr_x  in  8  destination column of sprite top-left
- spr_y  in  8  destination row of sprite top-left
- vga_blank_n  in  1  VGA_BLANK_N; 0 = blanking, writes allowed
- rom_addr  out  ADDR_W  sprite ROM read address
- rom_data  in  COLOR_W  ROM data; valid one cycle after rom_addr
- fb_we  out  1  frame-buffer write enable, 1 = write
- fb_addr  out  ADDR_W  frame-buffer write address
- fb_data  out  COLOR_W  colour index to write
- busy  out  1  high from the cycle after an accepted start through DONE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state, including mid-blit):
  - state goes to IDLE.
  - rom_addr, fb_addr, fb_data, row and col counters return to 0.
  - fb_we, busy and done return to 0.
  - No partial write is issued after Reset deasserts.
- IDLE:
  - If start=1, latch spr_id, spr_x and spr_y, clear row/col, then go to READ.
  - start while busy=1 is ignored; it is neither queued nor able to corrupt the latched inputs.
- READ (1 cycle):
  - rom_addr = spr_id*256 + row*SPR_W + col. Registered; shift and concatenate only, no multiplier.
  - Next state is WRITE.
- WRITE:
  - rom_data is valid here; rom_addr is held stable.
  - dx = spr_x+col and dy = spr_y+row, both zero-extended to 9 bits.
  - Clip when dx >= FB_W or dy >= FB_H.
  - fb_we=1 combinationally when vga_blank_n=0 AND not clipped AND rom_data != TRANSPARENT.
  - fb_addr = dy*FB_W + dx, truncated to ADDR_W. It is registered from the counters, so it is stable during WRITE.
  - fb_data = rom_data.
  - If vga_blank_n=1, stay in WRITE with fb_we=0 (stall); the pixel is retried when blanking begins.
  - Clipped or transparent pixels never stall: they advance regardless of vga_blank_n, with fb_we=0.
  - On advance, col increments. When col wraps from SPR_W-1 to 0, row increments.
  - After pixel (SPR_H-1, SPR_W-1), go to DONE; otherwise go back to READ.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- Latency: with start accepted in cycle t and vga_blank_n held 0:
  - busy=1 from t+1.
  - First possible fb_we at t+2.
  - Last WRITE at t+512.
  - done=1 at t+513.
  - busy=0 at t+514.
  - Each stall cycle adds 1.
- fb_we is 0 in every state except WRITE. fb_we is never high while vga_blank_n=1.
- Multiplications by FB_W use shift-add of constants. Intermediate width is 18 bits minimum, with no overflow for legal dx/dy.

Decomposition:
- Package pac_gfx_pkg holds:
  - FB_W, FB_H, SPR_W, SPR_H and TRANSPARENT constants
  - typedef color_idx_t (logic [3:0])
  - enum blit_state_t {IDLE, READ, WRITE, DONE}
- Sub-module blit_addr_gen (combinational):
  - inputs: spr_x, spr_y, row, col
  - outputs: fb_addr and clip flag
- Unit tests use the same pac_gfx_pkg constants.

Test Plan:
1. Reset, then start with spr_id=2, spr_x=10, spr_y=20, ROM filled with 4'h5, vga_blank_n=0.
   - Exactly 256 writes.
   - First fb_addr=20*226+10=4530; last fb_addr=35*226+25=7935.
   - done at t+513.
2. ROM checkerboard of 0 and 4'h3 → 128 writes only, all with data 4'h3; timing identical to scenario 1.
3. spr_x=220, spr_y=240 → writes only for dx<=225 and dy<=247 (6x8 = 48 writes); no fb_addr >= 226*248; done still at t+513.
4. vga_blank_n=1 for 100 cycles starting at t+5, then 0 → no fb_we during the window; 256 writes total; done delayed exactly by the stall count; rom_addr constant while stalled.
5. Second start pulse at t+50 with different spr_x → ignored; all addresses use the first spr_x; one done pulse.
6. Assert Reset at t+200 for 1 cycle → all outputs 0 immediately; IDLE afterwards; a new start completes normally with 256 correct writes.
